// File: rtl/icache_intc_bank_scheduler.sv
// ============================================================================
// icache_intc_bank_scheduler : round-robin share of one icache bank port,
// in-order ID FIFO routing bank responses back to the issuing core.
// Revision: 1.0
// ============================================================================
`default_nettype none

module icache_intc_bank_scheduler #(
  parameter int N_CORES         = 16,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int UID_WIDTH       = 20,
  parameter int DATA_WIDTH      = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [N_CORES-1:0]                      request_i,
  input  logic [N_CORES-1:0][ADDRESS_WIDTH-1:0]   address_i,
  input  logic [N_CORES-1:0][UID_WIDTH-1:0]       UID_i,
  output logic [N_CORES-1:0]                      grant_o,
  output logic                                    request_o,
  output logic [ADDRESS_WIDTH-1:0]                address_o,
  output logic [UID_WIDTH-1:0]                    UID_o,
  input  logic                                    grant_i,
  input  logic                                    resp_valid_i,
  input  logic [DATA_WIDTH-1:0]                   resp_data_i,
  output logic [N_CORES-1:0]                      resp_valid_o,
  output logic [DATA_WIDTH-1:0]                   resp_data_o,
  output logic                                    err_o
);

  localparam int IDX_W = $clog2(N_CORES);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0] LAST_CORE = IDX_W'(N_CORES - 1);

  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [IDX_W-1:0]      fifo_q [MAX_OUTSTANDING];
  logic [IDX_W-1:0]      fifo_d [MAX_OUTSTANDING];
  logic [N_CORES-1:0]    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  err_q, err_d;

  logic                  any_req;
  logic                  hi_found;
  logic [IDX_W-1:0]      hi_idx, lo_idx, winner;
  logic                  full, empty, handshake, pop;
  logic [IDX_W-1:0]      head;

  // Descending scan so the lowest index wins; the "hi" set covers indices at
  // or above the round-robin pointer, the "lo" set is the wrap-around fallback.
  always_comb begin
    any_req  = 1'b0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (request_i[i]) begin
        if (IDX_W'(i) >= rr_q) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
        any_req = 1'b1;
        lo_idx  = IDX_W'(i);
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
  end

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign request_o = any_req & ~full;
  assign handshake = request_o & grant_i;
  assign address_o = any_req ? address_i[winner] : '0;
  assign UID_o     = any_req ? UID_i[winner] : '0;
  assign pop       = resp_valid_i & ~empty;
  assign head      = fifo_q[rd_ptr_q];

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < N_CORES; i++) begin
      grant_o[i] = handshake && (winner == IDX_W'(i));
    end
  end

  always_comb begin
    rr_d     = rr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    fifo_d   = fifo_q;
    if (handshake) begin
      rr_d             = (winner == LAST_CORE) ? '0 : winner + IDX_W'(1);
      fifo_d[wr_ptr_q] = winner;
      wr_ptr_d         = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({handshake, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // A response with nothing outstanding is dropped and flagged until reset.
  always_comb begin
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    err_d        = err_q | (resp_valid_i & empty);
    if (pop) begin
      resp_data_d = resp_data_i;
      for (int i = 0; i < N_CORES; i++) begin
        resp_valid_d[i] = (head == IDX_W'(i));
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      rr_q         <= rr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign err_o        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_icache_intc_bank_scheduler.sv
// ============================================================================
// tb_icache_intc_bank_scheduler : directed and randomized checks of the bank
// scheduler against a queue-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_icache_intc_bank_scheduler;

  localparam int N    = 4;
  localparam int MAXO = 2;
  localparam int AW   = 32;
  localparam int UW   = 20;
  localparam int DW   = 128;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [N-1:0]           request_i;
  logic [N-1:0][AW-1:0]   address_i;
  logic [N-1:0][UW-1:0]   UID_i;
  logic [N-1:0]           grant_o;
  logic                   request_o;
  logic [AW-1:0]          address_o;
  logic [UW-1:0]          UID_o;
  logic                   grant_i;
  logic                   resp_valid_i;
  logic [DW-1:0]          resp_data_i;
  logic [N-1:0]           resp_valid_o;
  logic [DW-1:0]          resp_data_o;
  logic                   err_o;

  int vectors     = 0;
  int miscompares = 0;

  icache_intc_bank_scheduler #(
    .N_CORES(N), .ADDRESS_WIDTH(AW), .UID_WIDTH(UW),
    .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .request_i(request_i), .address_i(address_i), .UID_i(UID_i),
    .grant_o(grant_o), .request_o(request_o), .address_o(address_o), .UID_o(UID_o),
    .grant_i(grant_i), .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: pointer as an integer, outstanding cores as a queue.
  int           m_rr;
  int           m_q[$];
  bit           m_err;
  logic [N-1:0] m_rv;
  logic [DW-1:0] m_rdata;
  bit           m_req;
  int           m_win;
  logic [N-1:0] m_grant;
  logic [AW-1:0] m_addr;
  logic [UW-1:0] m_uid;
  logic [N-1:0] one = 1;

  task automatic model_reset();
    m_rr = 0;
    m_q.delete();
    m_err = 0;
    m_rv = '0;
    m_rdata = '0;
  endtask

  task automatic model_comb();
    bit found;
    found = 0;
    m_win = 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (!found && request_i[i]) begin
        found = 1;
        m_win = i;
      end
    end
    m_req   = found && (m_q.size() < MAXO);
    m_grant = (m_req && grant_i) ? (one << m_win) : '0;
    m_addr  = found ? address_i[m_win] : '0;
    m_uid   = found ? UID_i[m_win] : '0;
  endtask

  task automatic model_edge();
    m_rv = '0;
    if (resp_valid_i) begin
      if (m_q.size() > 0) begin
        m_rv    = one << m_q.pop_front();
        m_rdata = resp_data_i;
      end else begin
        m_err = 1;
      end
    end
    if (m_req && grant_i) begin
      m_q.push_back(m_win);
      m_rr = (m_win + 1) % N;
    end
  endtask

  task automatic drive(input logic [N-1:0] req, input logic gnt,
                       input logic rv, input logic [DW-1:0] d);
    @(negedge clk_i);
    request_i    = req;
    grant_i      = gnt;
    resp_valid_i = rv;
    resp_data_i  = d;
    #1;
    model_comb();
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic set_fields();
    for (int i = 0; i < N; i++) begin
      address_i[i] = 32'h1000_0000 + 32'(i * 16);
      UID_i[i]     = 20'(100 + i);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni       = 1'b0;
    request_i    = '0;
    grant_i      = 1'b0;
    resp_valid_i = 1'b0;
    resp_data_i  = '0;
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    request_i = '0; grant_i = 1'b0; resp_valid_i = 1'b0; resp_data_i = '0;
    set_fields();
    model_reset();
    #2;
    vectors++;
    if ({request_o, grant_o, resp_valid_o, err_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got req=%b gnt=%b rv=%b err=%b want all 0",
               request_o, grant_o, resp_valid_o, err_o);
    end
    vectors++;
    if (resp_data_o !== '0 || address_o !== '0 || UID_o !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got data=%h addr=%h uid=%h want 0", resp_data_o, address_o, UID_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_single();
    drive(4'b0001, 1'b1, 1'b0, '0);
    vectors++;
    if (grant_o !== 4'b0001 || request_o !== 1'b1) begin
      miscompares++;
      $display("FAIL single_grant: got gnt=%b req=%b want 0001 1", grant_o, request_o);
    end
    vectors++;
    if (address_o !== 32'h1000_0000 || UID_o !== 20'd100) begin
      miscompares++;
      $display("FAIL single_fields: got addr=%h uid=%0d want 10000000 100", address_o, UID_o);
    end
    tick();
    drive(4'b0000, 1'b0, 1'b1, 128'hA5);
    tick();
    vectors++;
    if (resp_valid_o !== 4'b0001 || resp_data_o !== 128'hA5) begin
      miscompares++;
      $display("FAIL single_resp: got rv=%b data=%h want 0001 a5", resp_valid_o, resp_data_o);
    end
    drive(4'b0000, 1'b0, 1'b0, 128'h77);
    tick();
    vectors++;
    if (resp_valid_o !== 4'b0000 || resp_data_o !== 128'hA5) begin
      miscompares++;
      $display("FAIL single_hold: got rv=%b data=%h want 0000 a5", resp_valid_o, resp_data_o);
    end
    // Pointer now at 1: core 1 must beat core 0; no grant_i means no move.
    drive(4'b0011, 1'b0, 1'b0, '0);
    vectors++;
    if (UID_o !== 20'd101 || grant_o !== 4'b0000 || request_o !== 1'b1) begin
      miscompares++;
      $display("FAIL single_rr: got uid=%0d gnt=%b req=%b want 101 0000 1", UID_o, grant_o, request_o);
    end
    tick();
    drive(4'b0011, 1'b1, 1'b0, '0);
    vectors++;
    if (grant_o !== 4'b0010) begin
      miscompares++;
      $display("FAIL single_rr_hold: got gnt=%b want 0010", grant_o);
    end
    tick();
    drive(4'b0000, 1'b0, 1'b1, 128'h1);
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(4'b1111, 1'b1, c > 0, DW'(c + 32'h50));
      vectors++;
      if (grant_o !== (one << (c % 4))) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got %b want %b", c, grant_o, one << (c % 4));
      end
      tick();
      if (c > 0) begin
        vectors++;
        if (resp_valid_o !== (one << ((c - 1) % 4)) || resp_data_o !== DW'(c + 32'h50)) begin
          miscompares++;
          $display("FAIL rr_resp[%0d]: got rv=%b data=%h want %b %h", c, resp_valid_o,
                   resp_data_o, one << ((c - 1) % 4), DW'(c + 32'h50));
        end
      end
    end
    drive(4'b0000, 1'b0, 1'b1, '0);
    tick();
  endtask

  task automatic test_outstanding();
    do_reset();
    drive(4'b1111, 1'b1, 1'b0, '0);
    tick();
    drive(4'b1111, 1'b1, 1'b0, '0);
    vectors++;
    if (grant_o !== 4'b0010) begin
      miscompares++;
      $display("FAIL limit_second: got %b want 0010", grant_o);
    end
    tick();
    drive(4'b1111, 1'b1, 1'b0, '0);
    vectors++;
    if (request_o !== 1'b0 || grant_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL limit_full: got req=%b gnt=%b want 0 0000", request_o, grant_o);
    end
    tick();
    drive(4'b1111, 1'b1, 1'b1, 128'hBEEF);
    vectors++;
    if (request_o !== 1'b0) begin
      miscompares++;
      $display("FAIL limit_no_bypass: got req=%b want 0", request_o);
    end
    tick();
    drive(4'b1111, 1'b1, 1'b0, '0);
    vectors++;
    if (request_o !== 1'b1 || grant_o !== 4'b0100) begin
      miscompares++;
      $display("FAIL limit_reopen: got req=%b gnt=%b want 1 0100", request_o, grant_o);
    end
    tick();
    drive(4'b0000, 1'b0, 1'b1, '0);
    tick();
    drive(4'b0000, 1'b0, 1'b1, '0);
    tick();
  endtask

  task automatic test_routing();
    do_reset();
    drive(4'b0100, 1'b1, 1'b0, '0);
    tick();
    drive(4'b0001, 1'b1, 1'b0, '0);
    tick();
    drive(4'b1000, 1'b1, 1'b1, 128'h11);
    tick();
    vectors++;
    if (resp_valid_o !== 4'b0100) begin
      miscompares++;
      $display("FAIL route_first: got %b want 0100", resp_valid_o);
    end
    // One outstanding: push core 3 while popping core 0.
    drive(4'b1000, 1'b1, 1'b1, 128'h22);
    vectors++;
    if (grant_o !== 4'b1000) begin
      miscompares++;
      $display("FAIL route_push_pop_grant: got %b want 1000", grant_o);
    end
    tick();
    vectors++;
    if (resp_valid_o !== 4'b0001 || resp_data_o !== 128'h22) begin
      miscompares++;
      $display("FAIL route_second: got rv=%b data=%h want 0001 22", resp_valid_o, resp_data_o);
    end
    drive(4'b0000, 1'b0, 1'b1, 128'h33);
    tick();
    vectors++;
    if (resp_valid_o !== 4'b1000 || err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL route_third: got rv=%b err=%b want 1000 0", resp_valid_o, err_o);
    end
  endtask

  task automatic test_spurious();
    drive(4'b0000, 1'b0, 1'b1, 128'h44);
    tick();
    vectors++;
    if (resp_valid_o !== 4'b0000 || err_o !== 1'b1 || resp_data_o !== 128'h33) begin
      miscompares++;
      $display("FAIL spurious: got rv=%b err=%b data=%h want 0000 1 33", resp_valid_o, err_o, resp_data_o);
    end
    drive(4'b0001, 1'b1, 1'b0, '0);
    tick();
    vectors++;
    if (err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %b want 1", err_o);
    end
    // Asynchronous reset with one request outstanding.
    @(negedge clk_i);
    rst_ni = 1'b0;
    request_i = '0; grant_i = 1'b0; resp_valid_i = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (err_o !== 1'b0 || resp_valid_o !== '0 || resp_data_o !== '0 || request_o !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got err=%b rv=%b data=%h req=%b want all 0",
               err_o, resp_valid_o, resp_data_o, request_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(4'b0000, 1'b0, 1'b1, 128'h55);
    tick();
    vectors++;
    if (err_o !== 1'b1 || resp_valid_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_discard: got err=%b rv=%b want 1 0000", err_o, resp_valid_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < N; i++) begin
      address_i[i] = AW'($urandom);
      UID_i[i]     = UW'($urandom);
    end
    for (int c = 0; c < 400; c++) begin
      logic rv;
      rv = (m_q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 49) == 0);
      drive(N'($urandom), $urandom_range(0, 3) != 0, rv,
            {$urandom, $urandom, $urandom, $urandom});
      vectors++;
      if (request_o !== m_req || grant_o !== m_grant) begin
        miscompares++;
        $display("FAIL rand_arb[%0d]: got req=%b gnt=%b want %b %b", c, request_o, grant_o, m_req, m_grant);
      end
      vectors++;
      if (address_o !== m_addr || UID_o !== m_uid) begin
        miscompares++;
        $display("FAIL rand_fields[%0d]: got %h %h want %h %h", c, address_o, UID_o, m_addr, m_uid);
      end
      tick();
      vectors++;
      if (resp_valid_o !== m_rv || resp_data_o !== m_rdata || err_o !== m_err) begin
        miscompares++;
        $display("FAIL rand_resp[%0d]: got rv=%b data=%h err=%b want %b %h %b", c,
                 resp_valid_o, resp_data_o, err_o, m_rv, m_rdata, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_outstanding();
    test_routing();
    test_spurious();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
